// File: rtl/alu_div_iter_pkg.sv
// Shared constants and types for the iterative radix-2 divider.
// Holds the default datapath width, FSM state encoding and latched operation mode.
package alu_div_iter_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int WORD_W       = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // Mode bits captured at acceptance and consumed in FIX.
    typedef struct packed {
        logic word;
        logic sign_q;
        logic sign_r;
    } div_mode_t;

endpackage

// File: rtl/alu_div_iter_core.sv
// Unsigned restoring shift/subtract engine: 32 or XLEN iterations, one quotient bit per cycle.
// The quotient and remainder registers hold their final values after the last step.
module alu_div_iter_core
    import alu_div_iter_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic            word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            last,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  dvsr;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    // The dividend is left-aligned in quo, so the next bit always leaves from the MSB
    // and a word-mode quotient ends up in quo[31:0] with zeros above it.
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvsr};
    assign last    = busy && (cnt == '0);

    // NOTE: every register in a clocked block is assigned with <= so all of them
    // update from the same pre-edge values; blocking = here would chain the steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            dvsr <= '0;
            quo  <= '0;
            rem  <= '0;
        end else if (flush) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= word ? CNT_W'(WORD_W - 1) : CNT_W'(XLEN - 1);
            dvsr <= divisor;
            quo  <= word ? (dividend << (XLEN - WORD_W)) : dividend;
            rem  <= '0;
        end else if (busy) begin
            quo <= {quo[XLEN-2:0], ~diff[XLEN]};
            rem <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_div_iter.sv
// RV64M iterative divider: sign handling, early exit for /0 and overflow, word-mode
// sign extension and valid/ready handshakes around the unsigned core.
module alu_div_iter
    import alu_div_iter_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            div_valid_i,
    output logic            div_ready_o,
    input  logic            signed_valid_i,
    input  logic            div32_valid_i,
    input  logic [XLEN-1:0] sr1_data_i,
    input  logic [XLEN-1:0] sr2_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] div_out_o,
    output logic [XLEN-1:0] rem_out_o
);

    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = ~XLEN'(32'h7FFF_FFFF);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    div_state_e      state;
    div_mode_t       mode_q;

    logic            word_op;
    logic [XLEN-1:0] a_sx, b_sx, a_zx, b_zx;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, overflow, accept, core_start;

    logic            core_last;
    logic [XLEN-1:0] core_quo, core_rem;
    logic [XLEN-1:0] q_fix, r_fix;

    assign div_ready_o = (state == DIV_IDLE);

    // Word operations only exist on RV64; an XLEN=32 build ignores div32_valid_i.
    assign word_op = div32_valid_i && (XLEN == 64);

    assign a_sx  = word_op ? sext32(sr1_data_i[31:0]) : sr1_data_i;
    assign b_sx  = word_op ? sext32(sr2_data_i[31:0]) : sr2_data_i;
    assign a_zx  = word_op ? XLEN'(sr1_data_i[31:0]) : sr1_data_i;
    assign b_zx  = word_op ? XLEN'(sr2_data_i[31:0]) : sr2_data_i;
    assign a_neg = signed_valid_i && a_sx[XLEN-1];
    assign b_neg = signed_valid_i && b_sx[XLEN-1];
    assign a_abs = a_neg ? -a_sx : a_zx;
    assign b_abs = b_neg ? -b_sx : b_zx;

    assign div_zero = (b_zx == '0);
    assign overflow = signed_valid_i && (a_sx == (word_op ? MIN_W : MIN_X)) && (b_sx == '1);

    assign accept     = div_ready_o && div_valid_i && !flush_i;
    assign core_start = accept && !div_zero && !overflow;

    alu_div_iter_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_i),
        .start    (core_start),
        .word     (word_op),
        .dividend (a_abs),
        .divisor  (b_abs),
        .last     (core_last),
        .quo      (core_quo),
        .rem      (core_rem)
    );

    // NOTE: both outputs get a value before any condition so no path leaves
    // them unassigned, which would otherwise infer a latch.
    always_comb begin
        q_fix = mode_q.sign_q ? -core_quo : core_quo;
        r_fix = mode_q.sign_r ? -core_rem : core_rem;
        if (mode_q.word) begin
            q_fix = sext32(q_fix[31:0]);
            r_fix = sext32(r_fix[31:0]);
        end
    end

    // NOTE: reset is synchronous and also clears the result registers, so a
    // mid-operation reset leaves no stale quotient or remainder on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DIV_IDLE;
            mode_q      <= '0;
            out_valid_o <= 1'b0;
            div_out_o   <= '0;
            rem_out_o   <= '0;
        end else if (flush_i) begin
            state       <= DIV_IDLE;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div_valid_i) begin
                        mode_q <= '{word: word_op, sign_q: a_neg ^ b_neg, sign_r: a_neg};
                        if (div_zero) begin
                            div_out_o   <= '1;
                            rem_out_o   <= a_sx;
                            out_valid_o <= 1'b1;
                            state       <= DIV_DONE;
                        end else if (overflow) begin
                            div_out_o   <= a_sx;
                            rem_out_o   <= '0;
                            out_valid_o <= 1'b1;
                            state       <= DIV_DONE;
                        end else begin
                            state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    if (core_last) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    div_out_o   <= q_fix;
                    rem_out_o   <= r_fix;
                    out_valid_o <= 1'b1;
                    state       <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule
